// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: redirect FSM state encodings and the PC step.
// Pure definitions, no logic.
package rv32_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } redir_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/redirect_target_sel.sv
// Purpose: picks the redirect target from the ID-stage branch/JAL or JALR address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the target is used.
module redirect_target_sel (
    input  logic        id_is_jalr,
    input  logic [31:0] branch_address,
    input  logic [31:0] jalr_address,
    output logic [31:0] target
);

    // JALR clears bit 0 of rs1+imm; when JAL and JALR both decode, JALR wins.
    assign target = id_is_jalr ? (jalr_address & ~32'd1) : branch_address;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Purpose: fetch PC sequencer with ID-stage redirect, one-cycle wrong-path flush and
//          saturating redirect counter; PC_REDIRECT_MISALIGN_TRAP_EN adds the misaligned-target trap.
// Latency: redirect target appears on pc one cycle after the accepting edge; if_flush is same-cycle.
// Backpressure: stall freezes pc, FSM state and counter; requests are ignored while stalled.
module pc_redirect_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic        id_branch_taken,
    input  logic        id_is_jal,
    input  logic        id_is_jalr,
    input  logic [31:0] branch_address,
    input  logic [31:0] jalr_address,
    output logic [31:0] pc,
    output logic        if_flush,
    output logic [15:0] redirect_count,
    output logic        misaligned_trap,
    output logic [31:0] bad_target
);

    redir_state_t state_q, state_d;
    logic [31:0]  pc_d;
    logic [15:0]  cnt_d;
    logic [31:0]  target;
    logic [31:0]  legal_tgt;
    logic         req;
    logic         accept;
    logic         trap_hit;

    redirect_target_sel u_tgt_sel (
        .id_is_jalr     (id_is_jalr),
        .branch_address (branch_address),
        .jalr_address   (jalr_address),
        .target         (target)
    );

    assign req = id_valid & (id_is_jal | id_is_jalr | (id_is_branch & id_branch_taken));

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    assign trap_hit  = target[1];
    assign legal_tgt = target;
`else
    // Without the trap, the low two target bits are simply dropped.
    assign trap_hit  = 1'b0;
    assign legal_tgt = {target[31:2], target[1:0] & 2'b00};
`endif

    assign accept   = (state_q == ST_RUN) & ~stall & req;
    assign if_flush = accept & rst_n;

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cnt_d   = redirect_count;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (req) begin
                        state_d = ST_FLUSH;
                        if (trap_hit) begin
                            pc_d = TRAP_VEC;
                        end else begin
                            pc_d = legal_tgt;
                            if (redirect_count != 16'hFFFF) begin
                                cnt_d = redirect_count + 16'd1;
                            end
                        end
                    end else begin
                        pc_d = pc + PC_INCR;
                    end
                end
            end
            ST_FLUSH: begin
                // Instruction in ID is wrong-path: ignore its request and step on.
                if (!stall) begin
                    pc_d    = pc + PC_INCR;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pc             <= RESET_PC;
            redirect_count <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc             <= pc_d;
            redirect_count <= cnt_d;
        end
    end

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_trap <= 1'b0;
            bad_target      <= 32'd0;
        end else begin
            misaligned_trap <= accept & trap_hit;
            if (accept & trap_hit) begin
                bad_target <= target;
            end
        end
    end
`else
    assign misaligned_trap = 1'b0;
    assign bad_target      = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed plus randomized bench for pc_redirect_ctrl against a behavioural PC model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_branch_taken;
    logic        id_is_jal;
    logic        id_is_jalr;
    logic [31:0] branch_address;
    logic [31:0] jalr_address;
    logic [31:0] pc;
    logic        if_flush;
    logic [15:0] redirect_count;
    logic        misaligned_trap;
    logic [31:0] bad_target;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch address, whether the next instruction is a wrong-path bubble,
    // number of redirects so far (capped), and trap outputs.
    logic [31:0] m_pc;
    bit          m_bubble;
    int          m_cnt;
    bit          m_trap;
    logic [31:0] m_bad;

    pc_redirect_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_branch_taken (id_branch_taken),
        .id_is_jal       (id_is_jal),
        .id_is_jalr      (id_is_jalr),
        .branch_address  (branch_address),
        .jalr_address    (jalr_address),
        .pc              (pc),
        .if_flush        (if_flush),
        .redirect_count  (redirect_count),
        .misaligned_trap (misaligned_trap),
        .bad_target      (bad_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_bubble = 1'b0;
        m_cnt    = 0;
        m_trap   = 1'b0;
        m_bad    = 32'd0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc"},    pc, m_pc);
        chk({tag, ".count"}, {16'd0, redirect_count}, m_cnt);
        chk({tag, ".trap"},  {31'd0, misaligned_trap}, {31'd0, m_trap});
        chk({tag, ".bad"},   bad_target, m_bad);
    endtask

    task automatic set_in(input bit st, input bit v, input bit br, input bit tk,
                          input bit jal, input bit jalr, input logic [31:0] ba, input logic [31:0] ja);
        stall = st; id_valid = v; id_is_branch = br; id_branch_taken = tk;
        id_is_jal = jal; id_is_jalr = jalr; branch_address = ba; jalr_address = ja;
    endtask

    // Called just after a falling edge with inputs already applied; returns on the next falling edge.
    task automatic tick(input string tag);
        bit          rq;
        bit          acc;
        logic [31:0] tg;
        rq  = id_valid && (id_is_jal || id_is_jalr || (id_is_branch && id_branch_taken));
        tg  = id_is_jalr ? {jalr_address[31:1], 1'b0} : branch_address;
        acc = !stall && !m_bubble && rq;
        #1;
        chk({tag, ".flush"}, {31'd0, if_flush}, {31'd0, acc});
        m_trap = 1'b0;
        if (!stall) begin
            if (m_bubble) begin
                m_pc     = m_pc + 32'd4;
                m_bubble = 1'b0;
            end else if (acc) begin
                m_bubble = 1'b1;
                if (TRAP_EN && tg[1]) begin
                    m_pc   = TRAP_VEC;
                    m_trap = 1'b1;
                    m_bad  = tg;
                end else begin
                    m_pc = TRAP_EN ? tg : (tg & 32'hFFFF_FFFC);
                    if (m_cnt < 65535) m_cnt++;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        model_reset();
        #1;
        chk("rst.flush", {31'd0, if_flush}, 32'd0);
        check_regs("rst");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.pc", pc, 32'h0);
        tick("seq1");
        chk("seq1.pc_abs", pc, 32'h4);
        tick("seq2");
        tick("seq3");
        chk("seq3.pc_abs", pc, 32'hC);
        tick("seq4");

        // JAL at 0x10, then a request in the bubble slot must be ignored.
        set_in(0, 1, 0, 0, 1, 0, 32'h40, 32'h0);
        tick("jal");
        chk("jal.pc_abs", pc, 32'h40);
        set_in(0, 1, 0, 0, 1, 0, 32'h800, 32'h0);
        tick("bubble");
        chk("bubble.pc_abs", pc, 32'h44);

        // JALR held off by a two-cycle stall.
        set_in(1, 1, 0, 0, 0, 1, 32'h0, 32'h81);
        tick("jalr_st1");
        tick("jalr_st2");
        set_in(0, 1, 0, 0, 0, 1, 32'h0, 32'h81);
        tick("jalr");
        chk("jalr.pc_abs", pc, 32'h80);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("jalr_bub");

        set_in(0, 1, 1, 0, 0, 0, 32'h1000, 32'h0);
        tick("br_nt");

        // JAL and JALR together: JALR target wins.
        set_in(0, 1, 0, 0, 1, 1, 32'h2000, 32'h3001);
        tick("both");
        chk("both.pc_abs", pc, 32'h3000);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("both_bub");

        // PC wrap at the top of the address space.
        set_in(0, 1, 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0);
        tick("to_top");
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("top_bub");
        tick("wrap");
        chk("wrap.pc_abs", pc, 32'h0);

        // Misaligned target.
        set_in(0, 1, 0, 0, 1, 0, 32'h202, 32'h0);
        tick("mis");
        chk("mis.pc_abs", pc, TRAP_EN ? 32'h100 : 32'h200);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("mis_after");
        tick("mis_after2");

        // Reset asserted while a redirect is being accepted.
        set_in(0, 1, 0, 0, 1, 0, 32'h300, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.flush", {31'd0, if_flush}, 32'd0);
        check_regs("midrst");
        @(posedge clk);
        #1;
        chk("midrst_hold.pc", pc, RESET_PC);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick("postrst");
        chk("postrst.pc_abs", pc, RESET_PC + 32'd4);

        // Counter saturation: preload one below the limit, then two redirects.
        force dut.redirect_count = 16'hFFFE;
        #1;
        release dut.redirect_count;
        m_cnt = 65534;
        set_in(0, 1, 1, 1, 0, 0, 32'h400, 32'h0);
        tick("sat1");
        chk("sat1.cnt_abs", {16'd0, redirect_count}, 32'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("sat_bub");
        set_in(0, 1, 1, 1, 0, 0, 32'h500, 32'h0);
        tick("sat2");
        chk("sat2.cnt_abs", {16'd0, redirect_count}, 32'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick("sat_bub2");

        // Reset the count and run random traffic.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                   1'($urandom), 1'($urandom),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                   $urandom, $urandom);
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap (MISALIGN_TRAP_EN only).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit stall; holds PC and FSM state.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_is_branch, id_branch_taken, id_is_jal, id_is_jalr  input  1 each  ID control-transfer decode and branch outcome.
REQ-008 branch_address  input  32  PC-relative target (branch/JAL).
REQ-009 jalr_address  input  32  rs1+imm target (JALR).
REQ-010 pc  output  32  current fetch PC.
REQ-011 if_flush  output  1  kill the IF/ID register this cycle.
REQ-012 redirect_count  output  16  saturating count of accepted redirects.
REQ-013 misaligned_trap  output  1  one-cycle trap pulse.
REQ-014 bad_target  output  32  last trapped target address.

Function
REQ-015 req = id_valid & (id_is_jal | id_is_jalr | (id_is_branch & id_branch_taken)).
REQ-016 target = id_is_jalr ? {jalr_address[31:1],1'b0} : branch_address; no other arithmetic.
REQ-017 FSM states: RUN, FLUSH; reset state RUN.
REQ-018 RUN, stall=1: pc, state, counter held; if_flush=0; req ignored until stall drops.
REQ-019 RUN, stall=0, req=0: pc <= pc+4 (wraps modulo 2^32 at 32'hFFFF_FFFC -> 0).
REQ-020 RUN, stall=0, req=1, target legal: if_flush=1 same cycle (combinational); pc <= target; redirect_count += 1 saturating at 16'hFFFF; state <= FLUSH.
REQ-021 FLUSH: req ignored (wrong-path bubble); if_flush=0; pc <= pc+4 unless stall=1 (then held, stay FLUSH); stall=0 -> RUN.
REQ-022 Redirect latency: target appears on pc exactly one cycle after accepting edge.
REQ-023 Simultaneous id_is_jal and id_is_jalr: JALR target wins.

Reset
REQ-024 rst_n low: immediately pc=RESET_PC, state=RUN, redirect_count=0, misaligned_trap=0, bad_target=0, if_flush=0.
REQ-025 Reset deassertion mid-redirect: no pending redirect survives; first post-reset edge fetches RESET_PC+4.

Configuration
REQ-026 Macro PC_REDIRECT_MISALIGN_TRAP_EN defined: target[1]=1 on accepted redirect -> no redirect, pc <= TRAP_VEC, if_flush=1, misaligned_trap=1 for one cycle, bad_target <= target, counter unchanged, state <= FLUSH.
REQ-027 Macro undefined: target[1] ignored (pc <= {target[31:2],2'b00}), misaligned_trap and bad_target tied 0, TRAP_VEC unused.

Structure
REQ-028 FSM state encodings and the 32'd4 PC increment constant reside in shared package rv32_pkg.
REQ-029 Target selection (REQ-016) is sub-module redirect_target_sel; remainder flat.

Verification
REQ-030 Reset release, stall=0, no req, 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; count 0.
REQ-031 pc=0x10, JAL, branch_address=0x40 -> if_flush=1 that cycle, pc=0x40 next, count=1; req at 0x40 ignored (FLUSH), pc=0x44.
REQ-032 JALR, jalr_address=0x81, stall=1 two cycles -> pc held; stall drop -> pc=0x80.
REQ-033 Branch id_branch_taken=0 -> no flush, pc+4; pc=0xFFFF_FFFC no req -> pc=0x0.
REQ-034 count preset by 65535 redirects -> one more redirect leaves count=0xFFFF.
REQ-035 MISALIGN_TRAP_EN, JAL branch_address=0x202 -> pc=0x100, misaligned_trap one cycle, bad_target=0x202; without macro -> pc=0x200.
